// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, screen codes and default timing for the game flow.
// GAME_PAUSE_EN widens the state to 3 bits and adds ST_PAUSE.
package game_pkg;
`ifdef GAME_PAUSE_EN
   localparam int ST_W = 3;
`else
   localparam int ST_W = 2;
`endif
   typedef enum logic [ST_W-1:0] {
      ST_START, ST_PLAY, ST_DYING, ST_OVER
`ifdef GAME_PAUSE_EN
      , ST_PAUSE
`endif
   } state_t;
   localparam logic [1:0] SCR_START = 2'd0;
   localparam logic [1:0] SCR_GAME  = 2'd1;
   localparam logic [1:0] SCR_BLANK = 2'd2;
   localparam logic [1:0] SCR_OVER  = 2'd3;
   localparam int DEATH_TICKS_DEF = 100;
   localparam int SPAWN_BASE_DEF  = 200;
   localparam int SPAWN_DEC_DEF   = 20;
   localparam int SPAWN_MIN_DEF   = 40;
   localparam int LEVEL_STEP_DEF  = 10;
   localparam int SCORE_W_DEF     = 14;
   // Guards the subtraction so a large level*dec never wraps below the floor.
   function automatic int spawn_interval(input logic [2:0] lvl, input int base, input int dec, input int mn);
      int d;
      d = int'(lvl) * dec;
      return (d >= base || base - d < mn) ? mn : base - d;
   endfunction
endpackage

// File: rtl/spawn_sched.sv
// spawn_sched: counts ticks while running and pulses spawn_req_o once per level-dependent interval.
module spawn_sched
   import game_pkg::*;
#(
   parameter int SPAWN_BASE = SPAWN_BASE_DEF,
   parameter int SPAWN_DEC  = SPAWN_DEC_DEF,
   parameter int SPAWN_MIN  = SPAWN_MIN_DEF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tick_i,
   input  logic       run_i,
   input  logic       clr_i,
   input  logic [2:0] level_i,
   output logic       spawn_req_o
);
   localparam int CW = $clog2(SPAWN_BASE + 1);
   logic [CW-1:0] cnt_q, cnt_d, last;
   logic hit, spawn_q;
   assign last = CW'(spawn_interval(level_i, SPAWN_BASE, SPAWN_DEC, SPAWN_MIN) - 1);
   // >= rather than == so a level-up that shortens the interval cannot strand the counter
   assign hit = run_i & tick_i & (cnt_q >= last);
   always_comb cnt_d = (clr_i | hit) ? '0 : (run_i & tick_i) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         spawn_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         spawn_q <= hit & ~clr_i;
      end
   end
   assign spawn_req_o = spawn_q;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: START/PLAY/DYING/OVER sequencer owning score, level, high score and spawn timing.
// Defining GAME_PAUSE_EN adds a PAUSE state toggled by enter during play.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int DEATH_TICKS = DEATH_TICKS_DEF,
   parameter int SPAWN_BASE  = SPAWN_BASE_DEF,
   parameter int SPAWN_DEC   = SPAWN_DEC_DEF,
   parameter int SPAWN_MIN   = SPAWN_MIN_DEF,
   parameter int LEVEL_STEP  = LEVEL_STEP_DEF,
   parameter int SCORE_W     = SCORE_W_DEF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               tick_i,
   input  logic               enter_i,
   input  logic               p_boom_i,
   input  logic               ep_boom_i,
   input  logic [3:0]         health_i,
   output logic [ST_W-1:0]    state_o,
   output logic               play_en_o,
   output logic               game_rst_o,
   output logic               spawn_req_o,
   output logic [2:0]         level_o,
   output logic [SCORE_W-1:0] score_o,
   output logic [SCORE_W-1:0] hi_score_o,
   output logic [1:0]         screen_sel_o
);
   localparam int KW = $clog2(LEVEL_STEP + 1);
   localparam int DW = $clog2(DEATH_TICKS + 1);
   state_t state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d, hi_q, hi_d;
   logic [2:0] level_q, level_d;
   logic [KW-1:0] kill_q, kill_d;
   logic [DW-1:0] death_q, death_d;
   logic [1:0] screen_d, screen_q;
   logic enter_q, enter_rise, start_game, kill, level_up, game_rst_q, play_en_q;
   // health alone decides death, so the hit pulse carries no extra information
   logic unused_p_boom;
   assign unused_p_boom = p_boom_i;
   assign enter_rise = enter_i & ~enter_q;
   assign start_game = enter_rise & (state_q == ST_START || state_q == ST_OVER);
   assign kill       = ep_boom_i & (state_q == ST_PLAY);
   assign level_up   = kill & (kill_q == KW'(LEVEL_STEP - 1));
   always_comb begin
      state_d  = state_q;
      death_d  = death_q;
      hi_d     = hi_q;
      score_d  = start_game ? '0 : (kill & ~&score_q) ? score_q + 1'b1 : score_q;
      kill_d   = (start_game | level_up) ? '0 : kill ? kill_q + 1'b1 : kill_q;
      level_d  = start_game ? '0 : (level_up && level_q != 3'd7) ? level_q + 1'b1 : level_q;
      case (state_q)
         ST_START: if (enter_rise) state_d = ST_PLAY;
         ST_PLAY: begin
            if (health_i == 4'd0) begin
               state_d = ST_DYING;
               death_d = '0;
            end
`ifdef GAME_PAUSE_EN
            else if (enter_rise) state_d = ST_PAUSE;
`endif
         end
         ST_DYING: begin
            if (tick_i && death_q == DW'(DEATH_TICKS - 1)) begin
               state_d = ST_OVER;
               hi_d    = (score_q > hi_q) ? score_q : hi_q;
            end else if (tick_i) death_d = death_q + 1'b1;
         end
         ST_OVER: if (enter_rise) state_d = ST_PLAY;
`ifdef GAME_PAUSE_EN
         ST_PAUSE: if (enter_rise) state_d = ST_PLAY;
`endif
         default: state_d = ST_START;
      endcase
      screen_d = (state_d == ST_START) ? SCR_START :
                 (state_d == ST_OVER) ? SCR_OVER :
                 (state_d == ST_DYING && death_d[3]) ? SCR_BLANK : SCR_GAME;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_START;
         enter_q    <= 1'b0;
         score_q    <= '0;
         hi_q       <= '0;
         level_q    <= '0;
         kill_q     <= '0;
         death_q    <= '0;
         screen_q   <= SCR_START;
         game_rst_q <= 1'b0;
         play_en_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         enter_q    <= enter_i;
         score_q    <= score_d;
         hi_q       <= hi_d;
         level_q    <= level_d;
         kill_q     <= kill_d;
         death_q    <= death_d;
         screen_q   <= screen_d;
         game_rst_q <= start_game;
         play_en_q  <= (state_d == ST_PLAY);
      end
   end
   spawn_sched #(
      .SPAWN_BASE(SPAWN_BASE),
      .SPAWN_DEC (SPAWN_DEC),
      .SPAWN_MIN (SPAWN_MIN)
   ) u_spawn (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tick_i     (tick_i),
      .run_i      (play_en_q),
      .clr_i      (start_game),
      .level_i    (level_q),
      .spawn_req_o(spawn_req_o)
   );
   assign state_o      = state_q;
   assign play_en_o    = play_en_q;
   assign game_rst_o   = game_rst_q;
   assign level_o      = level_q;
   assign score_o      = score_q;
   assign hi_score_o   = hi_q;
   assign screen_sel_o = screen_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed checks of the game flow, spawn timing, death/over and restart.
module tb_game_flow_ctrl;
   import game_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, enter = 1'b0, p_boom = 1'b0, ep_boom = 1'b0;
   logic [3:0] health = 4'd5;
   logic [ST_W-1:0] a_state, b_state;
   logic a_play, a_grst, a_spawn, b_play, b_grst, b_spawn;
   logic [2:0] a_level, b_level;
   logic [13:0] a_score, a_hi, b_score, b_hi;
   logic [1:0] a_screen, b_screen;
   int errs = 0, checks = 0, grst_n = 0;
   logic sa = 1'b0, sb = 1'b0;

   game_flow_ctrl u_dut (
      .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .enter_i(enter), .p_boom_i(p_boom),
      .ep_boom_i(ep_boom), .health_i(health), .state_o(a_state), .play_en_o(a_play),
      .game_rst_o(a_grst), .spawn_req_o(a_spawn), .level_o(a_level), .score_o(a_score),
      .hi_score_o(a_hi), .screen_sel_o(a_screen)
   );
   game_flow_ctrl #(.SPAWN_DEC(40)) u_dec40 (
      .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .enter_i(enter), .p_boom_i(p_boom),
      .ep_boom_i(ep_boom), .health_i(health), .state_o(b_state), .play_en_o(b_play),
      .game_rst_o(b_grst), .spawn_req_o(b_spawn), .level_o(b_level), .score_o(b_score),
      .hi_score_o(b_hi), .screen_sel_o(b_screen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
      if (a_grst) grst_n++;
   endtask
   task automatic tck();
      tick = 1'b1;
      cyc();
      sa = a_spawn;
      sb = b_spawn;
      tick = 1'b0;
      cyc();
   endtask
   task automatic kill();
      ep_boom = 1'b1;
      cyc();
      ep_boom = 1'b0;
      cyc();
   endtask
   task automatic press();
      enter = 1'b1;
      cyc();
      enter = 1'b0;
      cyc();
   endtask
   task automatic measure(input bit use_b, output int n);
      n = -1;
      for (int i = 1; i <= 500; i++) begin
         tck();
         if (use_b ? sb : sa) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n, nsp, first, last, seen1, seen2;
      repeat (3) cyc();
      chk("rst_state", 32'(a_state), 0);
      chk("rst_play_en", 32'(a_play), 0);
      chk("rst_game_rst", 32'(a_grst), 0);
      chk("rst_spawn", 32'(a_spawn), 0);
      chk("rst_level", 32'(a_level), 0);
      chk("rst_score", 32'(a_score), 0);
      chk("rst_hi", 32'(a_hi), 0);
      chk("rst_screen", 32'(a_screen), 0);
      rst_n = 1'b1;
      cyc();
      grst_n = 0;
      enter = 1'b1;
      repeat (50) cyc();
      enter = 1'b0;
      cyc();
      chk("start_grst_pulses", 32'(grst_n), 1);
      chk("start_state", 32'(a_state), 1);
      chk("start_play_en", 32'(a_play), 1);
      chk("start_screen", 32'(a_screen), 1);
      nsp = 0; first = 0; last = 0;
      for (int i = 1; i <= 400; i++) begin
         tck();
         if (sa) begin
            nsp++;
            if (first == 0) first = i;
            last = i;
         end
      end
      chk("spawn_count_400", 32'(nsp), 2);
      chk("spawn_first", 32'(first), 200);
      chk("spawn_last", 32'(last), 400);
      repeat (10) kill();
      chk("score_10", 32'(a_score), 10);
      chk("level_1", 32'(a_level), 1);
      measure(0, n);
      chk("interval_lvl1", 32'(n), 180);
      repeat (70) kill();
      chk("level_sat", 32'(a_level), 7);
      chk("score_80", 32'(a_score), 80);
      chk("b_level_sat", 32'(b_level), 7);
      chk("b_score_80", 32'(b_score), 80);
      chk("b_misc", {b_state, b_play, b_grst, b_hi, b_screen}, {2'(1), 1'b1, 1'b0, 14'd0, 2'd1});
      measure(0, n);
      chk("interval_lvl7", 32'(n), 60);
      measure(1, n);
      measure(1, n);
      chk("interval_floor", 32'(n), 40);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_state", 32'(a_state), 0);
      chk("midrst_play_en", 32'(a_play), 0);
      chk("midrst_level", 32'(a_level), 0);
      chk("midrst_score", 32'(a_score), 0);
      chk("midrst_screen", 32'(a_screen), 0);
      chk("midrst_spawn", 32'(a_spawn), 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      press();
      chk("game1_state", 32'(a_state), 1);
      repeat (5) kill();
      health = 4'd0;
      ep_boom = 1'b1;
      cyc();
      ep_boom = 1'b0;
      health = 4'd5;
      chk("die_score", 32'(a_score), 6);
      chk("die_state", 32'(a_state), 2);
      chk("die_play_en", 32'(a_play), 0);
      kill();
      chk("die_score_frozen", 32'(a_score), 6);
      seen1 = 0; seen2 = 0;
      for (int i = 1; i <= 99; i++) begin
         tck();
         if (a_screen == 2'd1) seen1++;
         if (a_screen == 2'd2) seen2++;
      end
      chk("dying_hold", 32'(a_state), 2);
      chk("blink_game", 32'(seen1), 51);
      chk("blink_blank", 32'(seen2), 48);
      tck();
      chk("over_state", 32'(a_state), 3);
      chk("over_hi", 32'(a_hi), 6);
      chk("over_screen", 32'(a_screen), 3);
      grst_n = 0;
      press();
      chk("restart_grst", 32'(grst_n), 1);
      chk("restart_state", 32'(a_state), 1);
      chk("restart_score", 32'(a_score), 0);
      chk("restart_hi", 32'(a_hi), 6);
      repeat (4) kill();
      health = 4'd0;
      cyc();
      health = 4'd5;
      repeat (100) tck();
      chk("game2_state", 32'(a_state), 3);
      chk("game2_score", 32'(a_score), 4);
      chk("game2_hi", 32'(a_hi), 6);
      press();
      repeat (50) tck();
      grst_n = 0;
      press();
`ifdef GAME_PAUSE_EN
      chk("pause_state", 32'(a_state), 4);
      chk("pause_play_en", 32'(a_play), 0);
      chk("pause_screen", 32'(a_screen), 1);
      nsp = 0;
      for (int i = 0; i < 300; i++) begin
         tck();
         if (sa) nsp++;
         if (i < 5) kill();
      end
      chk("pause_no_spawn", 32'(nsp), 0);
      chk("pause_score", 32'(a_score), 0);
      press();
      chk("resume_state", 32'(a_state), 1);
`else
      chk("enter_ignored_state", 32'(a_state), 1);
      chk("enter_ignored_play_en", 32'(a_play), 1);
`endif
      chk("play_enter_no_grst", 32'(grst_n), 0);
      measure(0, n);
      chk("interval_after_enter", 32'(n), 150);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
